// File: rtl/vga_scan_driver.sv
// -----------------------------------------------------------------------------
// vga_scan_driver
//
// Scan-side master of the image overlay path. Generates the raw pixel
// coordinate stream (VGA_X / VGA_Y) for the image-select / ROM-lookup logic and
// collects its draw_image and image_R/G/B responses after a fixed pipeline
// latency. Drives sync/blank outputs that line up with the returned pixel data.
// Where no image is present, the output is filled with the background colour.
//
// Ports:
//   clk                    system clock
//   reset                  asynchronous, active-high reset
//   pix_en                 pixel-step enable; every register advances only on it
//   bg_R/G/B      [7:0]    background colour, used where draw_image = 0
//   draw_image             image-present flag for the current VGA_X/VGA_Y
//                          (combinational from the coordinates upstream)
//   image_R/G/B   [7:0]    image pixel, returned P_LATENCY-1 steps after
//                          draw_image is valid
//   VGA_X/VGA_Y   [10:0]   registered raw h/v counters
//   VGA_R/G/B     [7:0]    pixel to DAC
//   VGA_HS/VGA_VS          syncs, active-low
//   VGA_BLANK_N            high in the visible region
//   VGA_SYNC_N             constant 0
//   frame_start            one-clk pulse after the step that loads (0,0)
//
// P_LATENCY is legal in the range 1..8.
// -----------------------------------------------------------------------------
module vga_scan_driver #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int P_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [7:0]  bg_R,
    input  logic [7:0]  bg_G,
    input  logic [7:0]  bg_B,
    input  logic        draw_image,
    input  logic [7:0]  image_R,
    input  logic [7:0]  image_G,
    input  logic [7:0]  image_B,
    output logic [10:0] VGA_X,
    output logic [10:0] VGA_Y,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line word: {hs_n, vs_n, blank_n, draw}. Idle = syncs inactive,
    // blanked, no image.
    localparam logic [3:0] STAGE_IDLE = 4'b1100;

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        frame_wrap;
    logic        frame_start_q;

    assign frame_wrap = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 11'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 11'd0;
            end else begin
                v_cnt_d = v_cnt_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= 11'd0;
            v_cnt_q <= 11'd0;
        end else if (pix_en) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // frame_start is a clk-wide pulse, not a pix-step-wide one, so it clears
    // on the very next clk regardless of pix_en. The reset-state (0,0) is not
    // reached through a wrap and therefore never pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && frame_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Stage-0 decode and delay line
    // ------------------------------------------------------------------
    logic       hs0_n;
    logic       vs0_n;
    logic       blank0_n;
    logic [3:0] stage0;
    logic [3:0] tap;

    assign hs0_n    = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vs0_n    = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign blank0_n = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    // draw_image belongs to the same coordinate as the decode, so it rides
    // in the same delay word.
    assign stage0   = {hs0_n, vs0_n, blank0_n, draw_image};

    // The output registers are the last of the P_LATENCY stages, so the line
    // itself holds P_LATENCY-1 stages; with P_LATENCY=1 the output registers
    // sample stage 0 directly.
    if (P_LATENCY == 1) begin : g_no_delay
        assign tap = stage0;
    end else begin : g_delay
        logic [3:0] dly_q [0:P_LATENCY-2];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < P_LATENCY - 1; i++) begin
                    dly_q[i] <= STAGE_IDLE;
                end
            end else if (pix_en) begin
                dly_q[0] <= stage0;
                for (int i = 1; i < P_LATENCY - 1; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign tap = dly_q[P_LATENCY-2];
    end

    // ------------------------------------------------------------------
    // Pixel mux and output registers
    // ------------------------------------------------------------------
    logic       tap_hs_n;
    logic       tap_vs_n;
    logic       tap_blank_n;
    logic       tap_draw;
    logic [7:0] r_d, g_d, b_d;
    logic [7:0] r_q, g_q, b_q;
    logic       hs_q, vs_q, blank_n_q;

    assign tap_hs_n    = tap[3];
    assign tap_vs_n    = tap[2];
    assign tap_blank_n = tap[1];
    assign tap_draw    = tap[0];

    // Blanking wins over draw: upstream may flag image pixels at off-screen
    // coordinates and those must never reach the DAC.
    always_comb begin
        r_d = 8'd0;
        g_d = 8'd0;
        b_d = 8'd0;
        if (tap_blank_n) begin
            if (tap_draw) begin
                r_d = image_R;
                g_d = image_G;
                b_d = image_B;
            end else begin
                r_d = bg_R;
                g_d = bg_G;
                b_d = bg_B;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (pix_en) begin
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= tap_hs_n;
            vs_q      <= tap_vs_n;
            blank_n_q <= tap_blank_n;
        end
    end

    assign VGA_X       = h_cnt_q;
    assign VGA_Y       = v_cnt_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_driver
//
// Small raster (32 x 15 totals) so several full frames fit in a short run.
// An upstream model answers draw_image combinationally from VGA_X and returns
// image_* one pix step later (P_LATENCY = 2). The driver pushes the expected
// output word for each pix step into exp_q. The monitor pops and compares the
// word on every step, and on idle clocks it checks that everything holds.
// -----------------------------------------------------------------------------
module tb_vga_scan_driver;

    localparam int HA    = 16;
    localparam int HFP   = 4;
    localparam int HSW   = 6;
    localparam int HBP   = 6;
    localparam int VA    = 8;
    localparam int VFP   = 2;
    localparam int VSW   = 2;
    localparam int VBP   = 3;
    localparam int P     = 2;
    localparam int HT    = HA + HFP + HSW + HBP;   // 32
    localparam int VT    = VA + VFP + VSW + VBP;   // 15
    localparam int COL   = 5;                      // visible image column
    localparam int GHOST = HA + 2;                 // image flagged in the porch

    // Pixel record: {R, G, B, hs_n, vs_n, blank_n}
    localparam logic [26:0] RESET_PIX = {24'h000000, 1'b1, 1'b1, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        pix_en;
    logic [7:0]  bg_R, bg_G, bg_B;
    logic        draw_image;
    logic [7:0]  image_R, image_G, image_B;
    logic [10:0] VGA_X, VGA_Y;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;

    vga_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .P_LATENCY(P)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .bg_R(bg_R), .bg_G(bg_G), .bg_B(bg_B),
        .draw_image(draw_image),
        .image_R(image_R), .image_G(image_G), .image_B(image_B),
        .VGA_X(VGA_X), .VGA_Y(VGA_Y),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .frame_start(frame_start)
    );

    // ---------------- upstream lookup model ----------------
    assign draw_image = (VGA_X == 11'(COL)) || (VGA_X == 11'(GHOST));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            {image_R, image_G, image_B} <= 24'h556677;
        end else if (pix_en) begin
            {image_R, image_G, image_B} <= draw_image ? 24'hAABBCC : 24'h556677;
        end
    end

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [49:0] exp_q[$];
    logic [49:0] last_exp;
    logic [26:0] flight_q[$];
    logic [26:0] cur_pix;
    int          mx, my;
    logic        mon_en = 1'b0;
    logic        stepped = 1'b0;
    int          hs_low_steps, vs_low_steps, fs_count;

    task automatic check(input string name, input logic [49:0] act, input logic [49:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got x=%0d y=%0d rgb=%h hs=%b vs=%b bl=%b fs=%b, expected x=%0d y=%0d rgb=%h hs=%b vs=%b bl=%b fs=%b",
                     name, $time, act[49:39], act[38:28], act[27:4], act[3], act[2], act[1], act[0],
                     exp[49:39], exp[38:28], exp[27:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [49:0] dut_word();
        return {VGA_X, VGA_Y, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start};
    endfunction

    // Expected output for a coordinate, straight from the timing description.
    function automatic logic [26:0] pix_rec(input int x, input int y);
        logic        hs_n, vs_n, bl_n;
        logic [23:0] rgb;
        hs_n = !((x >= HA + HFP) && (x < HA + HFP + HSW));
        vs_n = !((y >= VA + VFP) && (y < VA + VFP + VSW));
        bl_n = (x < HA) && (y < VA);
        if (!bl_n)                         rgb = 24'h000000;
        else if (x == COL || x == GHOST)   rgb = 24'hAABBCC;
        else                               rgb = 24'h112233;
        return {rgb, hs_n, vs_n, bl_n};
    endfunction

    task automatic model_reset();
        mx = 0;
        my = 0;
        flight_q.delete();
        exp_q.delete();
        flight_q.push_back(pix_rec(0, 0));   // reset state is pixel (0,0)
        cur_pix  = RESET_PIX;
        last_exp = {11'd0, 11'd0, RESET_PIX, 1'b0};
    endtask

    task automatic model_step();
        logic fs;
        mx++;
        if (mx == HT) begin
            mx = 0;
            my++;
            if (my == VT) my = 0;
        end
        fs = (mx == 0) && (my == 0);
        flight_q.push_back(pix_rec(mx, my));
        if (flight_q.size() > P) cur_pix = flight_q.pop_front();
        exp_q.push_back({11'(mx), 11'(my), cur_pix, fs});
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_step();
        @(negedge clk);
        model_step();
        pix_en = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_en = 1'b0;
        end
    endtask

    task automatic clear_counts();
        hs_low_steps = 0;
        vs_low_steps = 0;
        fs_count     = 0;
    endtask

    // Asynchronous reset mid-stream with pix_en held high.
    task automatic async_reset_check(input string name);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        pix_en = 1'b1;
        reset  = 1'b1;
        #1;
        check({name, "_immediate"}, dut_word(), {11'd0, 11'd0, RESET_PIX, 1'b0});
        check_int({name, "_sync_n"}, int'(VGA_SYNC_N), 0);
        repeat (2) @(negedge clk);
        check({name, "_held"}, dut_word(), {11'd0, 11'd0, RESET_PIX, 1'b0});
        pix_en = 1'b0;
        reset  = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) stepped <= pix_en && !reset;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (stepped) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty at %0t: got a pix step with no expected word", $time);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("pix_step", dut_word(), last_exp);
                    if (!VGA_HS) hs_low_steps++;
                    if (!VGA_VS) vs_low_steps++;
                    if (frame_start) fs_count++;
                end
            end else begin
                // Idle clock: everything holds; the frame_start pulse is gone.
                check("idle_hold", dut_word(), {last_exp[49:1], 1'b0});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;
        bg_R   = 8'h11;
        bg_G   = 8'h22;
        bg_B   = 8'h33;
        clear_counts();
        repeat (3) @(negedge clk);
        check("power_on_reset", dut_word(), {11'd0, 11'd0, RESET_PIX, 1'b0});

        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Run into the middle of the second line, then reset with pix_en high.
        for (int i = 0; i < 40; i++) do_step();
        async_reset_check("reset_midline");

        // First step after release: counters at (1,0).
        do_step();
        @(negedge clk);
        pix_en = 1'b0;
        #1;
        check_int("first_step_x", int'(VGA_X), 1);
        check_int("first_step_y", int'(VGA_Y), 0);
        idle(2);

        // Full-rate frame from the current position (x=1, y=0).
        clear_counts();
        for (int i = 0; i < HT * VT; i++) do_step();
        idle(1);
        check_int("hs_low_steps_frame", hs_low_steps, HSW * VT);
        check_int("vs_low_steps_frame", vs_low_steps, VSW * HT);
        check_int("frame_start_count", fs_count, 1);

        // Same scan with pix_en every 2nd..4th clk.
        clear_counts();
        for (int i = 0; i < HT * VT; i++) begin
            do_step();
            idle($urandom_range(1, 3));
        end
        check_int("gapped_hs_low_steps", hs_low_steps, HSW * VT);
        check_int("gapped_frame_start_count", fs_count, 1);

        // Move to (10,5) from wherever the scan sits, then reset mid-frame.
        while (!(mx == 10 && my == 5)) do_step();
        idle(1);
        check_int("pre_reset_x", int'(VGA_X), 10);
        check_int("pre_reset_y", int'(VGA_Y), 5);
        clear_counts();
        async_reset_check("reset_midframe");
        check_int("no_fs_on_reset", fs_count, 0);

        // One full frame after the restart: frame_start only on its last step.
        for (int i = 0; i < HT * VT - 1; i++) do_step();
        idle(1);
        check_int("no_fs_before_full_frame", fs_count, 0);
        do_step();
        idle(2);
        check_int("fs_after_full_frame", fs_count, 1);
        check_int("scan_back_at_origin_x", int'(VGA_X), 0);
        check_int("scan_back_at_origin_y", int'(VGA_Y), 0);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
